// File: rtl/line_pack_pkg.sv
// Shared types and constants for the line packer: FSM states, the header
// magic and the 34-bit FIFO word layout.
package line_pack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        READ   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;

    // One FIFO entry: framing flags plus the packed 32-bit payload.
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } word_t;

    // Header payload: magic in the top half, row index in the low 11 bits.
    function automatic logic [31:0] hdr_word(input logic [10:0] row);
        return {HDR_MAGIC, 5'b0, row};
    endfunction

endpackage

// File: rtl/pack_fifo.sv
// Show-ahead synchronous FIFO for packed output words. The head entry is
// presented on dout whenever valid is high; dout is forced to zero when
// the FIFO is empty or held in reset so downstream sees clean zeros.
module pack_fifo
    import line_pack_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  word_t         din,
    output logic          full,
    input  logic          pop,
    output word_t         dout,
    output logic          valid,
    output logic [CW-1:0] count
);

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0) && !rst;
    assign dout    = valid ? mem[rd_ptr] : '0;
    assign do_pop  = pop && valid;
    // A push on a full FIFO is only taken if the head leaves the same cycle.
    assign do_push = push && !rst && (!full || do_pop);

    // Storage array: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/line_packer.sv
// Reads one line of RGB565 pixels from an upstream line buffer and emits it
// as a header word followed by H_ACT/2 packed pixel words (even pixel in the
// upper half). Reads are throttled by FIFO credit so a stalled consumer never
// causes a word to be lost. H_ACT must be even.
module line_packer
    import line_pack_pkg::*;
#(
    parameter int H_ACT     = 1280,
    parameter int V_ACT     = 720,
    parameter int OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aquire,
    output logic        read_en,
    input  logic [15:0] cam_data,
    input  logic [10:0] cam_row,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        frame_done
);

    localparam int PW = $clog2(H_ACT + 1);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    state_t        state;
    logic [PW-1:0] pix_cnt;
    logic [10:0]   row_r;
    logic [10:0]   tx_row;      // row from the last header that left the FIFO
    logic [2:1]    vld_pipe;    // read_en history: [1] one cycle ago, [2] two
    logic          par_q;       // parity of the pixel now on cam_data
    logic          last_q;      // pixel now on cam_data is pixel H_ACT-1
    logic [15:0]   even_q;      // held even pixel waiting for its odd partner

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          push;
    word_t         push_word;
    word_t         pop_word;
    logic          hdr_push;
    logic          pix_push;
    logic [CW:0]   need;
    logic          credit_ok;
    logic          xfer;

    // A pixel word pushed this cycle has not yet shown up in fifo_count, so it
    // is charged as in flight; keeping two entries spare covers the even/odd
    // pair that can be outstanding behind it.
    assign pix_push  = vld_pipe[1] && par_q;
    assign hdr_push  = (state == HEADER) && !fifo_full;
    assign push      = hdr_push || pix_push;
    assign need      = {1'b0, fifo_count} + (CW+1)'(pix_push) + (CW+1)'(2);
    assign credit_ok = (need <= (CW+1)'(OUT_DEPTH));

    // Gated with rst so an in-progress line stops pulling pixels immediately.
    assign read_en = !rst && (state == READ) && (pix_cnt < PW'(H_ACT)) && credit_ok;

    // Header and pixel pushes never coincide: HEADER is only reached after two
    // quiet read_en cycles, so no returned pixel is pending then.
    always_comb begin
        push_word = '0;
        if (hdr_push) begin
            push_word.sop  = 1'b1;
            push_word.data = hdr_word(row_r);
        end else begin
            push_word.eop  = last_q;
            push_word.data = {even_q, cam_data};
        end
    end

    // Line sequencing FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pix_cnt <= '0;
            row_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aquire && (vld_pipe == 2'b00)) begin
                        row_r <= cam_row;
                        state <= HEADER;
                    end
                end
                HEADER: begin
                    if (!fifo_full) begin
                        pix_cnt <= '0;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (read_en) begin
                        pix_cnt <= pix_cnt + PW'(1);
                        if (pix_cnt == PW'(H_ACT - 1)) state <= DRAIN;
                    end
                end
                // The last pixel returns and is pushed during this cycle.
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return pipeline and even-pixel holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            par_q    <= 1'b0;
            last_q   <= 1'b0;
            even_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], read_en};
            if (read_en) begin
                par_q  <= pix_cnt[0];
                last_q <= (pix_cnt == PW'(H_ACT - 1));
            end
            if (vld_pipe[1] && !par_q) even_q <= cam_data;
        end
    end

    pack_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_word),
        .full  (fifo_full),
        .pop   (tx_ready),
        .dout  (pop_word),
        .valid (tx_valid),
        .count (fifo_count)
    );

    assign xfer    = tx_valid && tx_ready;
    assign tx_data = pop_word.data;
    assign tx_sop  = pop_word.sop;
    assign tx_eop  = pop_word.eop;

    // Track the row of the line currently leaving, taken from its header.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_row <= '0;
        end else if (xfer && pop_word.sop) begin
            tx_row <= pop_word.data[10:0];
        end
    end

    assign frame_done = xfer && pop_word.eop && (tx_row == 11'(V_ACT - 1));

endmodule

// File: tb/tb_line_packer.sv
// Directed bench for line_packer with H_ACT=8, V_ACT=2, OUT_DEPTH=4.
module tb_line_packer;

    localparam int H = 8;
    localparam int V = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aquire = 1'b0;
    logic        read_en;
    logic [15:0] cam_data;
    logic [10:0] cam_row = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        fd;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    int ready_mode = 0;     // 0 low, 1 high, 2 random 30%
    int rd_idx;
    int line_rd = 0;
    int lines_read = 0;
    int gap = 0;
    int gap_checks = 0;
    int xfers = 0;
    int frames = 0;
    bit seen_read = 0;

    line_packer #(
        .H_ACT     (H),
        .V_ACT     (V),
        .OUT_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .aquire     (aquire),
        .read_en    (read_en),
        .cam_data   (cam_data),
        .cam_row    (cam_row),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_sop     (tx_sop),
        .tx_eop     (tx_eop),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Upstream line buffer: pixel value is {row[7:0], index}, one cycle after read_en.
    always @(posedge clk) begin
        if (rst) begin
            rd_idx   <= 0;
            cam_data <= '0;
        end else if (read_en) begin
            cam_data <= {cam_row[7:0], 8'(rd_idx)};
            rd_idx   <= (rd_idx == H - 1) ? 0 : rd_idx + 1;
        end
    end

    // Consumer ready pattern.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = ($urandom_range(0, 99) < 30);
        endcase
    end

    // Monitor and scoreboard, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            line_rd   = 0;
            seen_read = 0;
            gap       = 0;
        end else begin
            chk("fifo_count_bound", 64'(dut.u_fifo.count <= D), 64'd1);
            chk("push_while_full", 64'(dut.u_fifo.push && dut.u_fifo.full), 64'd0);
            if (read_en) begin
                if (line_rd == 0 && seen_read) begin
                    chk("read_gap_ge2", 64'(gap >= 2), 64'd1);
                    gap_checks++;
                end
                seen_read = 1;
                gap = 0;
                line_rd++;
                if (line_rd == H) begin
                    line_rd = 0;
                    lines_read++;
                end
            end else begin
                gap++;
            end
            if (frame_done) frames++;
            if (tx_valid && tx_ready) begin
                xfers++;
                if (expq.size() == 0) begin
                    chk("unexpected_word", 64'(tx_valid), 64'd0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("tx_data", 64'(tx_data), 64'(mon_e.data));
                    chk("tx_sop", 64'(tx_sop), 64'(mon_e.sop));
                    chk("tx_eop", 64'(tx_eop), 64'(mon_e.eop));
                    chk("frame_done", 64'(frame_done), 64'(mon_e.fd));
                end
            end else begin
                chk("frame_done_idle", 64'(frame_done), 64'd0);
            end
        end
    end

    task automatic push_line(input logic [10:0] row);
        exp_t w;
        w.data = {16'hA55A, 5'b0, row};
        w.sop = 1'b1; w.eop = 1'b0; w.fd = 1'b0;
        expq.push_back(w);
        for (int k = 0; k < H / 2; k++) begin
            w.data = {row[7:0], 8'(2 * k), row[7:0], 8'(2 * k + 1)};
            w.sop  = 1'b0;
            w.eop  = (k == H / 2 - 1);
            w.fd   = (k == H / 2 - 1) && (row == 11'(V - 1));
            expq.push_back(w);
        end
    endtask

    // Offer one line and return once all of its pixels have been read.
    task automatic run_line(input logic [10:0] row);
        int start;
        int t;
        start = lines_read;
        cam_row = row;
        push_line(row);
        aquire = 1'b1;
        t = 0;
        while (lines_read == start && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("line_read_count", 64'(lines_read - start), 64'd1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_left", 64'(expq.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int x0, l0, f0, r15, t;
        // Reset state
        rst = 1'b1;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_en", 64'(read_en), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_tx_sop", 64'(tx_sop), 64'd0);
        chk("rst_tx_eop", 64'(tx_eop), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single line, row 5, free-running consumer
        x0 = xfers; l0 = lines_read;
        run_line(11'd5);
        aquire = 1'b0;
        wait_drain();
        chk("words_row5", 64'(xfers - x0), 64'd5);
        chk("lines_row5", 64'(lines_read - l0), 64'd1);
        chk("extra_reads_row5", 64'(line_rd), 64'd0);

        // Back-to-back rows 0 and 1 with aquire held: frame end on row 1
        f0 = frames;
        run_line(11'd0);
        run_line(11'd1);
        aquire = 1'b0;
        wait_drain();
        chk("frame_done_once", 64'(frames - f0), 64'd1);
        chk("gap_checks_made", 64'(gap_checks >= 2), 64'd1);

        // Consumer stalled for >50 cycles; aquire dropped once the line starts
        ready_mode = 0;
        @(posedge clk); #1;
        l0 = lines_read;
        cam_row = 11'd9;
        push_line(11'd9);
        aquire = 1'b1;
        repeat (3) @(posedge clk);
        #1 aquire = 1'b0;
        repeat (12) @(posedge clk);
        #1 r15 = line_rd;
        chk("stall_some_reads", 64'(r15 > 0), 64'd1);
        repeat (38) @(posedge clk);
        #1;
        chk("stall_no_read", 64'(line_rd), 64'(r15));
        chk("stall_line_open", 64'(lines_read - l0), 64'd0);
        ready_mode = 1;
        wait_drain();
        chk("stall_line_done", 64'(lines_read - l0), 64'd1);
        chk("stall_reads_exact", 64'(line_rd), 64'd0);

        // Reset at pix_cnt=3, then a clean line
        cam_row = 11'd20;
        push_line(11'd20);
        aquire = 1'b1;
        t = 0;
        while (line_rd != 3 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("reach_pix3", 64'(line_rd), 64'd3);
        rst = 1'b1;
        aquire = 1'b0;
        @(negedge clk);
        chk("midrst_read_en", 64'(read_en), 64'd0);
        chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
        expq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("postrst_read_en", 64'(read_en), 64'd0);
        chk("postrst_tx_valid", 64'(tx_valid), 64'd0);
        x0 = xfers;
        run_line(11'd21);
        aquire = 1'b0;
        wait_drain();
        chk("words_after_rst", 64'(xfers - x0), 64'd5);

        // 100 lines against a 30% duty consumer
        ready_mode = 2;
        l0 = lines_read; f0 = frames; x0 = xfers;
        for (int i = 0; i < 100; i++) run_line(11'(100 + i));
        aquire = 1'b0;
        wait_drain();
        ready_mode = 1;
        chk("random_lines", 64'(lines_read - l0), 64'd100);
        chk("random_words", 64'(xfers - x0), 64'd500);
        chk("random_no_frame", 64'(frames - f0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
